// File: rtl/response_arbiter.sv
// Response arbiter: one command unit owns the response path; its words and trailer go into a FWFT FIFO.
// Push-to-out_valid latency 1 cycle; out_ready backpressure gates rsp_room/grants, and a push into a full FIFO is dropped.

module response_arbiter_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_rdy,
    output logic [W-1:0]           head_dat,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign do_pop   = pop_rdy && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

module response_arbiter #(
    parameter int NUNITS        = 4,
    parameter int FIFO_DEPTH    = 64,
    parameter int MAX_RSP_WORDS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_start,
    input  logic [$clog2(NUNITS)-1:0] cmd_unit,
    output logic                      rsp_room,
    input  logic [NUNITS*33-1:0]      unit_param_data,
    input  logic [NUNITS-1:0]         unit_param_write,
    input  logic [NUNITS-1:0]         unit_cmd_done,
    input  logic [NUNITS-1:0]         unit_invol_req,
    output logic [NUNITS-1:0]         unit_invol_grant,
    output logic [32:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      err
);
    localparam int UW = $clog2(NUNITS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [UW:0]   NU_C    = (UW+1)'(NUNITS);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXW_C  = CW'(MAX_RSP_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_INVOL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [UW-1:0]     owner_q, owner_d;
    logic [UW-1:0]     rr_q, rr_d;
    logic [7:0]        len_q, len_d;
    logic [NUNITS-1:0] grant_q, grant_d;
    logic              err_q, err_d;

    logic [31:0]       pdata [NUNITS];
    logic [NUNITS-1:0] pdata_msbs;
    logic              unused_pdata_msbs;

    logic              push_vld;
    logic [32:0]       push_dat;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     fifo_free;

    logic [NUNITS-1:0] owner_oh;
    logic              own_wr;
    logic              own_done;
    logic [31:0]       own_data;

    logic              rr_found;
    logic [UW-1:0]     rr_win;
    logic [UW:0]       rr_sum;
    logic [UW:0]       rr_next;

    for (genvar i = 0; i < NUNITS; i++) begin : g_unpack
        assign pdata[i]      = unit_param_data[i*33 +: 32];
        assign pdata_msbs[i] = unit_param_data[i*33 + 32];
    end
    // Bit 32 of each unit's param_data carries nothing the response path needs.
    assign unused_pdata_msbs = ^pdata_msbs;

    assign owner_oh  = NUNITS'(1) << owner_q;
    assign own_wr    = unit_param_write[owner_q];
    assign own_done  = unit_cmd_done[owner_q];
    assign own_data  = pdata[owner_q];
    assign fifo_free = DEPTH_C - fifo_count;
    assign rsp_room  = (state_q == S_IDLE) && (fifo_free >= MAXW_C);

    // Round-robin search starting at rr_q, wrapping modulo NUNITS.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        rr_sum   = '0;
        for (int k = 0; k < NUNITS; k++) begin
            rr_sum = {1'b0, rr_q} + (UW+1)'(k);
            if (rr_sum >= NU_C) begin
                rr_sum = rr_sum - NU_C;
            end
            if (!rr_found && unit_invol_req[rr_sum[UW-1:0]]) begin
                rr_found = 1'b1;
                rr_win   = rr_sum[UW-1:0];
            end
        end
        rr_next = {1'b0, rr_win} + (UW+1)'(1);
        if (rr_next >= NU_C) begin
            rr_next = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        len_d    = len_q;
        grant_d  = '0;
        err_d    = err_q;
        push_vld = 1'b0;
        push_dat = '0;
        case (state_q)
            S_IDLE: begin
                if ((|unit_param_write) || (|unit_cmd_done)) begin
                    err_d = 1'b1;
                end
                if (cmd_start) begin
                    state_d = S_CMD;
                    owner_d = cmd_unit;
                    if (!rsp_room) begin
                        err_d = 1'b1;
                    end
                end else if (rsp_room && rr_found) begin
                    state_d = S_INVOL;
                    owner_d = rr_win;
                    rr_d    = rr_next[UW-1:0];
                    grant_d = NUNITS'(1) << rr_win;
                end
            end
            S_CMD, S_INVOL: begin
                if (((unit_param_write | unit_cmd_done) & ~owner_oh) != '0) begin
                    err_d = 1'b1;
                end
                if (own_done) begin
                    // The trailer wins; a payload word in the same cycle is lost.
                    push_vld = 1'b1;
                    push_dat = {1'b1, len_q, own_data[23:0]};
                    len_d    = '0;
                    state_d  = S_IDLE;
                    if (own_wr) begin
                        err_d = 1'b1;
                    end
                end else if (own_wr) begin
                    push_vld = 1'b1;
                    push_dat = {1'b0, own_data};
                    if (len_q == 8'hFF) begin
                        err_d = 1'b1;
                    end else begin
                        len_d = len_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (push_vld && fifo_full && !out_ready) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            len_q   <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            len_q   <= len_d;
            grant_q <= grant_d;
            err_q   <= err_d;
        end
    end

    response_arbiter_fifo #(
        .W     (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (out_ready),
        .head_dat (out_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    assign out_valid        = !fifo_empty;
    assign busy             = (state_q != S_IDLE);
    assign unit_invol_grant = grant_q;
    assign err              = err_q;
endmodule

// File: tb/tb_response_arbiter.sv
// Directed bench for response_arbiter: framing, round-robin grants, priority, backpressure, foreign writes, reset.
module tb_response_arbiter;
    localparam int NUNITS = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_start = 1'b0;
    logic [1:0]        cmd_unit = '0;
    logic              rsp_room;
    logic [NUNITS*33-1:0] unit_param_data = '0;
    logic [NUNITS-1:0] unit_param_write = '0;
    logic [NUNITS-1:0] unit_cmd_done = '0;
    logic [NUNITS-1:0] unit_invol_req = '0;
    logic [NUNITS-1:0] unit_invol_grant;
    logic [32:0]       out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              err;

    int checks = 0;
    int fails = 0;

    response_arbiter #(
        .NUNITS        (4),
        .FIFO_DEPTH    (64),
        .MAX_RSP_WORDS (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_start        (cmd_start),
        .cmd_unit         (cmd_unit),
        .rsp_room         (rsp_room),
        .unit_param_data  (unit_param_data),
        .unit_param_write (unit_param_write),
        .unit_cmd_done    (unit_cmd_done),
        .unit_invol_req   (unit_invol_req),
        .unit_invol_grant (unit_invol_grant),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy),
        .err              (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_start = 1'b0;
        unit_param_write = '0;
        unit_cmd_done = '0;
        unit_invol_req = '0;
        out_ready = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic set_data(input int u, input logic [32:0] d);
        unit_param_data[u*33 +: 33] = d;
    endtask

    task automatic start(input int u);
        cmd_start = 1'b1;
        cmd_unit = 2'(u);
        cyc();
        cmd_start = 1'b0;
    endtask

    task automatic pw(input int u, input logic [31:0] w);
        set_data(u, {1'b0, w});
        unit_param_write[u] = 1'b1;
        cyc();
        unit_param_write[u] = 1'b0;
    endtask

    task automatic done(input int u, input logic [23:0] code);
        set_data(u, {9'h0, code});
        unit_cmd_done[u] = 1'b1;
        cyc();
        unit_cmd_done[u] = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [32:0] exp);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk(tag, 64'(out_data), 64'(exp));
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic [32:0] last;

        // 1: simple command frame
        do_reset();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_grant", 64'(unit_invol_grant), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        start(1);
        chk("t1_busy", 64'(busy), 64'(1));
        chk("t1_room_cmd", 64'(rsp_room), 64'(0));
        pw(1, 32'h11);
        chk("t1_valid_first", 64'(out_valid), 64'(1));
        pw(1, 32'h22);
        done(1, 24'h05);
        chk("t1_idle", 64'(busy), 64'(0));
        pop_expect("t1_w0", {1'b0, 32'h11});
        pop_expect("t1_w1", {1'b0, 32'h22});
        pop_expect("t1_trl", {1'b1, 32'h0200_0005});
        chk("t1_empty", 64'(out_valid), 64'(0));
        chk("t1_err", 64'(err), 64'(0));

        // 2: involuntary round-robin
        do_reset();
        unit_invol_req = 4'b0101;
        cyc();
        chk("t2_grant0", 64'(unit_invol_grant), 64'(4'b0001));
        chk("t2_busy", 64'(busy), 64'(1));
        unit_invol_req[0] = 1'b0;
        cyc();
        chk("t2_pulse", 64'(unit_invol_grant), 64'(0));
        pw(0, 32'hA0);
        done(0, 24'h01);
        chk("t2_idle_nogrant", 64'(unit_invol_grant), 64'(0));
        cyc();
        chk("t2_grant2", 64'(unit_invol_grant), 64'(4'b0100));
        unit_invol_req = '0;
        done(2, 24'h02);
        unit_invol_req = 4'b1100;
        cyc();
        chk("t2_grant3_rr", 64'(unit_invol_grant), 64'(4'b1000));
        unit_invol_req = '0;
        done(3, 24'h00);
        pop_expect("t2_w0", {1'b0, 32'hA0});
        pop_expect("t2_trl0", {1'b1, 32'h0100_0001});
        pop_expect("t2_trl2", {1'b1, 32'h0000_0002});
        pop_expect("t2_trl3", {1'b1, 32'h0000_0000});
        chk("t2_err", 64'(err), 64'(0));

        // 3: cmd_start beats invol_req
        do_reset();
        unit_invol_req = 4'b0010;
        cmd_start = 1'b1;
        cmd_unit = 2'd3;
        cyc();
        cmd_start = 1'b0;
        chk("t3_busy", 64'(busy), 64'(1));
        chk("t3_nogrant", 64'(unit_invol_grant), 64'(0));
        pw(3, 32'h33);
        chk("t3_nogrant_cmd", 64'(unit_invol_grant), 64'(0));
        done(3, 24'h09);
        chk("t3_nogrant_done", 64'(unit_invol_grant), 64'(0));
        cyc();
        chk("t3_grant1", 64'(unit_invol_grant), 64'(4'b0010));
        unit_invol_req = '0;
        done(1, 24'h00);
        pop_expect("t3_w0", {1'b0, 32'h33});
        pop_expect("t3_trl", {1'b1, 32'h0100_0009});
        chk("t3_err", 64'(err), 64'(0));

        // 4: backpressure and full FIFO
        do_reset();
        start(0);
        for (int i = 0; i < 56; i++) begin
            pw(0, 32'(i));
        end
        done(0, 24'h00);
        chk("t4_room_low", 64'(rsp_room), 64'(0));
        chk("t4_idle", 64'(busy), 64'(0));
        unit_invol_req = 4'b0010;
        cyc();
        cyc();
        chk("t4_nogrant", 64'(unit_invol_grant), 64'(0));
        chk("t4_stay_idle", 64'(busy), 64'(0));
        unit_invol_req = '0;
        chk("t4_err_clean", 64'(err), 64'(0));
        pop_expect("t4_head0", {1'b0, 32'h0});
        chk("t4_room_back", 64'(rsp_room), 64'(1));
        start(0);
        for (int i = 0; i < 8; i++) begin
            pw(0, 32'h100 + 32'(i));
        end
        chk("t4_err_full", 64'(err), 64'(0));
        pw(0, 32'h200);
        chk("t4_err_drop", 64'(err), 64'(1));
        set_data(0, {1'b0, 32'h300});
        unit_param_write[0] = 1'b1;
        out_ready = 1'b1;
        cyc();
        unit_param_write[0] = 1'b0;
        out_ready = 1'b0;
        chk("t4_head_after_pp", 64'(out_data), 64'({1'b0, 32'h2}));
        done(0, 24'h07);
        chk("t4_idle2", 64'(busy), 64'(0));
        n = 0;
        last = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && out_valid; i++) begin
            last = out_data;
            n++;
            cyc();
        end
        out_ready = 1'b0;
        chk("t4_drain_count", 64'(n), 64'(64));
        chk("t4_last_word", 64'(last), 64'({1'b0, 32'h300}));

        // 5: foreign write while another unit owns
        do_reset();
        start(1);
        pw(1, 32'hAA);
        set_data(2, {1'b0, 32'hDEAD});
        unit_param_write[2] = 1'b1;
        cyc();
        unit_param_write[2] = 1'b0;
        chk("t5_err", 64'(err), 64'(1));
        pw(1, 32'hBB);
        done(1, 24'h03);
        pop_expect("t5_w0", {1'b0, 32'hAA});
        pop_expect("t5_w1", {1'b0, 32'hBB});
        pop_expect("t5_trl", {1'b1, 32'h0200_0003});
        chk("t5_empty", 64'(out_valid), 64'(0));

        // 6: reset mid-response
        do_reset();
        start(2);
        pw(2, 32'h77);
        chk("t6_valid", 64'(out_valid), 64'(1));
        set_data(0, {1'b0, 32'h1});
        unit_param_write[0] = 1'b1;
        cyc();
        unit_param_write[0] = 1'b0;
        chk("t6_err_set", 64'(err), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_rst", 64'(out_valid), 64'(0));
        chk("t6_busy_rst", 64'(busy), 64'(0));
        chk("t6_grant_rst", 64'(unit_invol_grant), 64'(0));
        chk("t6_err_rst", 64'(err), 64'(0));
        chk("t6_data_rst", 64'(out_data), 64'(0));
        do_reset();
        start(1);
        done(1, 24'h04);
        pop_expect("t6_fresh_trl", {1'b1, 32'h0000_0004});
        chk("t6_empty", 64'(out_valid), 64'(0));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
